job_issuer: RTL
===============

// Module: job_issuer
// PURPOSE
//  Host-side driver of the CAPI job-control interface: issues the PSL reset (0x80) and start (0x90) commands
//  with the WED address, generates odd parity, and tracks ah_jrunning/ah_jdone/ah_jerror from the AFU job block.
//  Used as the PSL stand-in for AFU bring-up and in the on-chip loopback harness; one job outstanding at a time.
// PARAMETERS
//  TIMEOUT_CYCLES  1000000  max cycles waited in any wait state before aborting with timeout status
//  CNT_W           20       width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  ha_pclock    in   1     clock
//  reset_n      in   1     asynchronous active-low reset
//  job_req      in   1     request a job; accepted when job_ack=1
//  job_ack      out  1     high in IDLE only; req&ack = accept (WED latched)
//  job_wed      in   64    WED effective address [0:63], latched on accept
//  inj_par_err  in   1     sampled on accept; if 1 the start command's jcompar is inverted
//  ha_jval      out  1     job command valid, single-cycle pulse
//  ha_jcom      out  8     job command [0:7]: 0x80 reset, 0x90 start
//  ha_jcompar   out  1     odd parity of ha_jcom
//  ha_jea       out  64    job effective address [0:63]
//  ha_jeapar    out  1     odd parity of ha_jea
//  ah_jrunning  in   1     AFU running
//  ah_jdone     in   1     AFU done pulse
//  ah_jerror    in   64    AFU error word, valid with ah_jdone
//  job_busy     out  1     high in every state except IDLE
//  job_end      out  1     1-cycle pulse: job finished (any status)
//  job_status   out  2     00 ok, 01 AFU error (jerror!=0), 10 timeout; held until next accept
//  job_error    out  64    ah_jerror captured at start-phase ah_jdone; held until next accept
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, ha_jval=0, ha_jcom=0, ha_jea=0, ha_jcompar=1, ha_jeapar=1,
//   job_busy=0, job_end=0, job_status=00, job_error=0, counter=0. All outputs registered.
//  Parity: jcompar = ~^ha_jcom, jeapar = ~^ha_jea (total ones incl. parity bit odd). Idle values 0/1.
//  States: IDLE -> RST_CMD -> RST_WAIT -> START_CMD -> RUN_WAIT -> RUNNING -> FINISH -> IDLE.
//  IDLE: job_ack=1. On job_req: latch job_wed, inj_par_err; job_status<=00, job_error<=0; go RST_CMD.
//  RST_CMD (1 cycle): drive ha_jval=1, ha_jcom=0x80, ha_jea=0 -> RST_WAIT. Commands visible cycle after entry.
//  RST_WAIT: wait ah_jdone (ah_jerror ignored) -> START_CMD. Min 1 idle jval-low cycle between commands.
//  START_CMD (1 cycle): ha_jval=1, ha_jcom=0x90, ha_jea=WED, jcompar inverted if inj_par_err -> RUN_WAIT.
//  RUN_WAIT: ah_jrunning=1 -> RUNNING; ah_jdone=1 (with or without running) -> FINISH directly.
//  RUNNING: ah_jdone=1 -> FINISH. ah_jrunning dropping without jdone is not an error; keep waiting.
//  FINISH (1 cycle): job_error<=ah_jerror value captured at the jdone cycle; job_status<=01 if nonzero else 00;
//   job_end=1; -> IDLE. job_end is exactly one cycle after the jdone cycle.
//  ha_jval/ha_jcom/ha_jea return to 0 (parity to 1) the cycle after each command pulse.
//  Timeout: counter clears on entry to RST_WAIT, RUN_WAIT, RUNNING (RUN_WAIT->RUNNING clears it); increments each
//   wait cycle. If counter reaches TIMEOUT_CYCLES-1 with no exit event: job_status<=10, job_end pulse, -> IDLE.
//   jdone in the same cycle as expiry wins (normal completion).
//  ah_jdone in IDLE/RST_CMD/START_CMD/FINISH ignored. job_req outside IDLE ignored (no queueing).
//  reset_n asserted mid-job: abort immediately to reset values; no job_end emitted.
// TESTING
//  1 Accept WED=0x0000_0000_1234_5680; AFU jdone 3 cyc after reset cmd, running 2 cyc after start, jdone 10 later
//    -> jval pulses: jcom=0x80 jea=0 jcompar=0 jeapar=1; then jcom=0x90 jea=WED jcompar=1; job_end, status 00.
//  2 Same, ah_jerror=0x0000_0000_0000_0004 with final jdone -> job_status=01, job_error=0x...04, job_end 1 cycle.
//  3 inj_par_err=1 -> start command jcompar=0 with jcom=0x90; reset command parity unaffected.
//  4 TIMEOUT_CYCLES=16, AFU never asserts jdone after reset cmd -> job_end 16 cycles after RST_WAIT entry, status 10.
//  5 jdone in RUN_WAIT without ah_jrunning -> FINISH, status 00; also jdone on expiry cycle -> status 00.
//  6 reset_n low during RUNNING -> all outputs to reset values same cycle, job_ack=1 after release, no job_end.

Source files
------------

// File: rtl/job_issuer.sv
// Job-control command issuer: reset/start sequencing toward the AFU job block,
// odd parity generation and completion/timeout tracking (one job at a time).

package job_issuer_pkg;

    localparam int unsigned COM_W  = 8;
    localparam int unsigned EA_W   = 64;
    localparam int unsigned STAT_W = 2;

    localparam logic [COM_W-1:0] COM_RESET = 8'h80;
    localparam logic [COM_W-1:0] COM_START = 8'h90;

    localparam logic [STAT_W-1:0] STAT_OK      = 2'b00;
    localparam logic [STAT_W-1:0] STAT_AFU_ERR = 2'b01;
    localparam logic [STAT_W-1:0] STAT_TIMEOUT = 2'b10;

    // Job command bus payload as presented to the AFU
    typedef struct packed {
        logic             val;
        logic [COM_W-1:0] com;
        logic             compar;
        logic [EA_W-1:0]  ea;
        logic             eapar;
    } job_cmd_t;

    // Quiet bus: everything zero, parity bits odd-fill to 1
    localparam job_cmd_t CMD_IDLE = '{
        val:    1'b0,
        com:    '0,
        compar: 1'b1,
        ea:     '0,
        eapar:  1'b1
    };

    // Build a valid command with odd parity; flip corrupts the command parity on purpose
    function automatic job_cmd_t make_cmd(
        input logic [COM_W-1:0] com,
        input logic [EA_W-1:0]  ea,
        input logic             flip
    );
        job_cmd_t c;
        c.val    = 1'b1;
        c.com    = com;
        c.compar = (~^com) ^ flip;
        c.ea     = ea;
        c.eapar  = ~^ea;
        return c;
    endfunction

endpackage

module job_issuer
    import job_issuer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic              ha_pclock,
    input  logic              reset_n,
    input  logic              job_req,
    output logic              job_ack,
    input  logic [EA_W-1:0]   job_wed,
    input  logic              inj_par_err,
    output logic              ha_jval,
    output logic [COM_W-1:0]  ha_jcom,
    output logic              ha_jcompar,
    output logic [EA_W-1:0]   ha_jea,
    output logic              ha_jeapar,
    input  logic              ah_jrunning,
    input  logic              ah_jdone,
    input  logic [EA_W-1:0]   ah_jerror,
    output logic              job_busy,
    output logic              job_end,
    output logic [STAT_W-1:0] job_status,
    output logic [EA_W-1:0]   job_error
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RST_CMD,
        RST_WAIT,
        START_CMD,
        RUN_WAIT,
        RUNNING,
        FINISH
    } state_t;

    logic [1:0]        rst_sync_q;
    logic              rst_n;

    state_t            state_q, state_d;
    job_cmd_t          cmd_q, cmd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [EA_W-1:0]   wed_q, wed_d;
    logic              inj_q, inj_d;
    logic              ack_q;
    logic              busy_q;
    logic              end_q, end_d;
    logic [STAT_W-1:0] status_q, status_d;
    logic [EA_W-1:0]   error_q, error_d;
    logic              expired_c;

    // Reset asserts asynchronously, releases on the clock
    always_ff @(posedge ha_pclock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    assign expired_c = (cnt_q == CNT_LAST);

    // State register and registered outputs
    always_ff @(posedge ha_pclock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cmd_q    <= CMD_IDLE;
            cnt_q    <= '0;
            wed_q    <= '0;
            inj_q    <= 1'b0;
            ack_q    <= 1'b1;
            busy_q   <= 1'b0;
            end_q    <= 1'b0;
            status_q <= STAT_OK;
            error_q  <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            cnt_q    <= cnt_d;
            wed_q    <= wed_d;
            inj_q    <= inj_d;
            ack_q    <= (state_d == IDLE);
            busy_q   <= (state_d != IDLE);
            end_q    <= end_d;
            status_q <= status_d;
            error_q  <= error_d;
        end
    end

    // Next-state, command and completion logic; exit events beat the timeout
    always_comb begin
        state_d  = state_q;
        cmd_d    = CMD_IDLE;
        cnt_d    = cnt_q;
        wed_d    = wed_q;
        inj_d    = inj_q;
        end_d    = 1'b0;
        status_d = status_q;
        error_d  = error_q;

        case (state_q)
            IDLE: begin
                if (job_req) begin
                    wed_d    = job_wed;
                    inj_d    = inj_par_err;
                    status_d = STAT_OK;
                    error_d  = '0;
                    state_d  = RST_CMD;
                end
            end

            RST_CMD: begin
                cmd_d   = make_cmd(COM_RESET, '0, 1'b0);
                cnt_d   = '0;
                state_d = RST_WAIT;
            end

            RST_WAIT: begin
                if (ah_jdone) begin
                    state_d = START_CMD;
                end else if (expired_c) begin
                    end_d    = 1'b1;
                    status_d = STAT_TIMEOUT;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            START_CMD: begin
                cmd_d   = make_cmd(COM_START, wed_q, inj_q);
                cnt_d   = '0;
                state_d = RUN_WAIT;
            end

            RUN_WAIT: begin
                if (ah_jdone) begin
                    end_d    = 1'b1;
                    error_d  = ah_jerror;
                    status_d = (|ah_jerror) ? STAT_AFU_ERR : STAT_OK;
                    state_d  = FINISH;
                end else if (ah_jrunning) begin
                    cnt_d   = '0;
                    state_d = RUNNING;
                end else if (expired_c) begin
                    end_d    = 1'b1;
                    status_d = STAT_TIMEOUT;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RUNNING: begin
                if (ah_jdone) begin
                    end_d    = 1'b1;
                    error_d  = ah_jerror;
                    status_d = (|ah_jerror) ? STAT_AFU_ERR : STAT_OK;
                    state_d  = FINISH;
                end else if (expired_c) begin
                    end_d    = 1'b1;
                    status_d = STAT_TIMEOUT;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign job_ack    = ack_q;
    assign job_busy   = busy_q;
    assign job_end    = end_q;
    assign job_status = status_q;
    assign job_error  = error_q;
    assign ha_jval    = cmd_q.val;
    assign ha_jcom    = cmd_q.com;
    assign ha_jcompar = cmd_q.compar;
    assign ha_jea     = cmd_q.ea;
    assign ha_jeapar  = cmd_q.eapar;

endmodule
